// File: rtl/mcont_multi_chnbuf_reg.sv
`default_nettype none
// ============================================================================
// mcont_multi_chnbuf_reg : shared channel decode, one-hot done/page strobes,
// per-channel read-page pointers and saturating pending-done counters.
// Revision 1.0
// ============================================================================
module mcont_multi_chnbuf_reg #(
  parameter int                          NUM_CHN       = 16,
  parameter int                          CHN_WIDTH     = 4,
  parameter logic [(1<<CHN_WIDTH)-1:0]   CHN_MASK      = '1,
  parameter int                          PAGE_BITS     = 2,
  parameter int                          DONE_CNT_BITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHN_WIDTH-1:0]           ext_buf_rchn,
  input  logic                           ext_buf_rpage_nxt,
  input  logic                           seq_done,
  input  logic [NUM_CHN-1:0]             done_ack,
  input  logic [NUM_CHN-1:0]             page_rst,
  output logic [NUM_CHN-1:0]             buf_done,
  output logic [NUM_CHN-1:0]             rpage_nxt,
  output logic [NUM_CHN*PAGE_BITS-1:0]   rpage,
  output logic [NUM_CHN-1:0]             done_pending,
  output logic [NUM_CHN-1:0]             done_ovfl
);

  logic [NUM_CHN-1:0] sel_c;
  logic [NUM_CHN-1:0] chn_sel_r;
  logic [NUM_CHN-1:0] buf_done_r;
  logic [NUM_CHN-1:0] rpage_nxt_r;

  // Channel numbers at or above NUM_CHN have no decoder and select nothing.
  generate
    for (genvar n = 0; n < NUM_CHN; n++) begin : g_dec
      assign sel_c[n] = (ext_buf_rchn == CHN_WIDTH'(n)) && CHN_MASK[n];
    end
  endgenerate

  // seq_done refers to the channel presented one cycle earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chn_sel_r   <= '0;
      buf_done_r  <= '0;
      rpage_nxt_r <= '0;
    end else begin
      chn_sel_r   <= sel_c;
      buf_done_r  <= chn_sel_r & {NUM_CHN{seq_done}};
      rpage_nxt_r <= sel_c & {NUM_CHN{ext_buf_rpage_nxt}};
    end
  end

  assign buf_done  = buf_done_r;
  assign rpage_nxt = rpage_nxt_r;

  generate
    for (genvar n = 0; n < NUM_CHN; n++) begin : g_chn
      logic [PAGE_BITS-1:0]     page_r;
      logic [DONE_CNT_BITS-1:0] cnt_r;
      logic                     ovfl_r;
      logic                     inc;
      logic                     ack;

      assign inc = buf_done_r[n];
      assign ack = done_ack[n];

      // Simultaneous inc and ack cancel, so a full counter does not flag overflow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          page_r <= '0;
          cnt_r  <= '0;
          ovfl_r <= 1'b0;
        end else if (page_rst[n]) begin
          page_r <= '0;
          cnt_r  <= '0;
          ovfl_r <= 1'b0;
        end else begin
          if (rpage_nxt_r[n])
            page_r <= page_r + PAGE_BITS'(1);
          if (inc && !ack) begin
            if (&cnt_r)
              ovfl_r <= 1'b1;
            else
              cnt_r <= cnt_r + DONE_CNT_BITS'(1);
          end else if (ack && !inc && (cnt_r != '0)) begin
            cnt_r <= cnt_r - DONE_CNT_BITS'(1);
          end
        end
      end

      assign rpage[n*PAGE_BITS +: PAGE_BITS] = page_r;
      assign done_pending[n]                 = (cnt_r != '0);
      assign done_ovfl[n]                    = ovfl_r;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mcont_multi_chnbuf_reg.sv
`default_nettype none
// ============================================================================
// tb_mcont_multi_chnbuf_reg : directed and random stimulus against a
// channel-level reference model.  Revision 1.0
// ============================================================================
module tb_mcont_multi_chnbuf_reg;

  localparam int          NUM_CHN       = 12;
  localparam int          CHN_WIDTH     = 4;
  localparam logic [15:0] CHN_MASK      = 16'hfffe;
  localparam int          PAGE_BITS     = 2;
  localparam int          DONE_CNT_BITS = 3;
  localparam int          CNT_MAX       = (1 << DONE_CNT_BITS) - 1;
  localparam int          NUM_PAGES     = 1 << PAGE_BITS;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [CHN_WIDTH-1:0]         ext_buf_rchn = '0;
  logic                         ext_buf_rpage_nxt = 1'b0;
  logic                         seq_done = 1'b0;
  logic [NUM_CHN-1:0]           done_ack = '0;
  logic [NUM_CHN-1:0]           page_rst = '0;
  logic [NUM_CHN-1:0]           buf_done;
  logic [NUM_CHN-1:0]           rpage_nxt;
  logic [NUM_CHN*PAGE_BITS-1:0] rpage;
  logic [NUM_CHN-1:0]           done_pending;
  logic [NUM_CHN-1:0]           done_ovfl;

  mcont_multi_chnbuf_reg #(
    .NUM_CHN(NUM_CHN), .CHN_WIDTH(CHN_WIDTH), .CHN_MASK(CHN_MASK),
    .PAGE_BITS(PAGE_BITS), .DONE_CNT_BITS(DONE_CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .ext_buf_rchn(ext_buf_rchn),
    .ext_buf_rpage_nxt(ext_buf_rpage_nxt), .seq_done(seq_done),
    .done_ack(done_ack), .page_rst(page_rst), .buf_done(buf_done),
    .rpage_nxt(rpage_nxt), .rpage(rpage), .done_pending(done_pending),
    .done_ovfl(done_ovfl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: channel-level view of counters, pages and strobes.
  int                 m_cnt  [NUM_CHN];
  int                 m_page [NUM_CHN];
  bit                 m_ovfl [NUM_CHN];
  int                 m_prev_sel = -1;
  logic [NUM_CHN-1:0] m_bd  = '0;
  logic [NUM_CHN-1:0] m_rpn = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int chn_of(input int rchn);
    if (rchn < NUM_CHN && CHN_MASK[rchn]) return rchn;
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_CHN; n++) begin
      m_cnt[n] = 0; m_page[n] = 0; m_ovfl[n] = 0;
    end
    m_prev_sel = -1; m_bd = '0; m_rpn = '0;
  endtask

  task automatic model_clock(input int rchn, input bit rpn, input bit sd,
                             input logic [NUM_CHN-1:0] ack, input logic [NUM_CHN-1:0] prst);
    int sel;
    sel = chn_of(rchn);
    for (int n = 0; n < NUM_CHN; n++) begin
      if (prst[n]) begin
        m_cnt[n] = 0; m_ovfl[n] = 0; m_page[n] = 0;
      end else begin
        if (m_rpn[n]) m_page[n] = (m_page[n] + 1) % NUM_PAGES;
        if (m_bd[n] && !ack[n]) begin
          if (m_cnt[n] == CNT_MAX) m_ovfl[n] = 1;
          else m_cnt[n] = m_cnt[n] + 1;
        end else if (ack[n] && !m_bd[n] && m_cnt[n] > 0) begin
          m_cnt[n] = m_cnt[n] - 1;
        end
      end
    end
    m_bd  = (m_prev_sel >= 0 && sd)  ? (NUM_CHN'(1) << m_prev_sel) : '0;
    m_rpn = (sel >= 0 && rpn)        ? (NUM_CHN'(1) << sel)        : '0;
    m_prev_sel = sel;
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CHN*PAGE_BITS-1:0] epg;
    logic [NUM_CHN-1:0]           epend, eovf;
    for (int n = 0; n < NUM_CHN; n++) begin
      epg[n*PAGE_BITS +: PAGE_BITS] = PAGE_BITS'(m_page[n]);
      epend[n] = (m_cnt[n] != 0);
      eovf[n]  = m_ovfl[n];
    end
    chk({tag, ".buf_done"},     64'(buf_done),     64'(m_bd));
    chk({tag, ".rpage_nxt"},    64'(rpage_nxt),    64'(m_rpn));
    chk({tag, ".rpage"},        64'(rpage),        64'(epg));
    chk({tag, ".done_pending"}, 64'(done_pending), 64'(epend));
    chk({tag, ".done_ovfl"},    64'(done_ovfl),    64'(eovf));
  endtask

  // Drive inputs, take one clock edge, advance the model and compare.
  task automatic step(input string tag, input int rchn, input bit rpn, input bit sd,
                      input logic [NUM_CHN-1:0] ack = '0, input logic [NUM_CHN-1:0] prst = '0);
    ext_buf_rchn      = CHN_WIDTH'(rchn);
    ext_buf_rpage_nxt = rpn;
    seq_done          = sd;
    done_ack          = ack;
    page_rst          = prst;
    @(posedge clk);
    model_clock(rchn, rpn, sd, ack, prst);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".buf_done"},     64'(buf_done),     64'd0);
    chk({tag, ".rpage_nxt"},    64'(rpage_nxt),    64'd0);
    chk({tag, ".rpage"},        64'(rpage),        64'd0);
    chk({tag, ".done_pending"}, 64'(done_pending), 64'd0);
    chk({tag, ".done_ovfl"},    64'(done_ovfl),    64'd0);
  endtask

  localparam logic [NUM_CHN-1:0] CH1 = NUM_CHN'(1) << 1;
  localparam logic [NUM_CHN-1:0] CH2 = NUM_CHN'(1) << 2;
  localparam logic [NUM_CHN-1:0] CH5 = NUM_CHN'(1) << 5;

  initial begin
    model_reset();
    #1;
    check_zero("reset");
    #2 rst = 1'b0;

    // Done on channel 5
    step("sel5", 5, 0, 0);
    step("done5", 15, 0, 1);
    chk("done5.onehot", 64'(buf_done), 64'h020);
    step("pend5", 15, 0, 0);
    chk("pend5.bit", 64'(done_pending[5]), 64'd1);
    step("ack5", 15, 0, 0, CH5);

    // Five page advances on channel 3
    for (int i = 0; i < 5; i++) begin
      step("rpn3", 3, 1, 0);
      chk("rpn3.strobe", 64'(rpage_nxt), 64'h008);
      step("rpn3_idle", 15, 0, 0);
    end
    chk("rpn3.page", 64'(rpage[3*PAGE_BITS +: PAGE_BITS]), 64'd1);

    // Saturate channel 2, overflow, drain with acks
    step("sel2", 2, 0, 0);
    for (int i = 0; i < 8; i++) step("done2", 2, 0, 1);
    step("done2_tail", 15, 0, 0);
    step("done2_tail", 15, 0, 0);
    chk("sat2.ovfl", 64'(done_ovfl[2]), 64'd1);
    for (int i = 0; i < 7; i++) step("ack2", 15, 0, 0, CH2);
    chk("drain2.pending", 64'(done_pending[2]), 64'd0);
    step("ack2_extra", 15, 0, 0, CH2);
    chk("drain2.ovfl", 64'(done_ovfl[2]), 64'd1);
    step("prst2", 15, 0, 0, '0, CH2);
    chk("prst2.ovfl", 64'(done_ovfl[2]), 64'd0);

    // Counter full, then done and ack together
    step("sel2b", 2, 0, 0);
    for (int i = 0; i < 7; i++) step("fill2", 2, 0, 1);
    step("fill2_last", 15, 0, 1);
    step("inc_ack2", 15, 0, 0, CH2);
    chk("inc_ack2.ovfl", 64'(done_ovfl[2]), 64'd0);
    chk("inc_ack2.pending", 64'(done_pending[2]), 64'd1);
    step("prst2b", 15, 0, 0, '0, CH2);

    // Masked channel 0 and out-of-range channel 15
    step("mask0", 0, 1, 0);
    step("mask0", 0, 1, 1);
    chk("mask0.rpn", 64'(rpage_nxt), 64'd0);
    step("oor15", 15, 1, 1);
    step("oor15", 15, 1, 1);
    chk("oor15.bd", 64'(buf_done), 64'd0);
    chk("oor15.rpn", 64'(rpage_nxt), 64'd0);

    // Channel 1 to counter 4 and page 2, then reset with a done in flight
    step("prst1", 15, 0, 0, '0, CH1);
    step("sel1", 1, 1, 0);
    step("fill1", 1, 1, 1);
    step("fill1", 1, 0, 1);
    step("fill1", 1, 0, 1);
    step("fill1", 1, 0, 1);
    step("fill1_tail", 15, 0, 0);
    chk("fill1.page", 64'(rpage[1*PAGE_BITS +: PAGE_BITS]), 64'd2);
    step("sel1_inflight", 1, 0, 0);
    ext_buf_rchn = 4'd15;
    seq_done     = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    seq_done = 1'b0;
    #1 rst = 1'b0;
    step("post_rst", 15, 0, 0);
    step("post_rst", 15, 0, 0);
    chk("post_rst.pending1", 64'(done_pending[1]), 64'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [NUM_CHN-1:0] ack, prst;
      ack  = NUM_CHN'($urandom() & $urandom() & $urandom());
      prst = ($urandom_range(0, 15) == 0) ? NUM_CHN'($urandom()) : '0;
      step("rand", int'($urandom_range(0, 15)), 1'($urandom()), 1'($urandom_range(0, 3) != 0),
           ack, prst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
